// File: rtl/native_pkg.sv
// Shared definitions for the native valid/ready slave blocks: FSM encoding,
// default bus widths and the byte-offset width helper.
package native_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Number of low address bits that select a byte within one word.
    function automatic int byte_off_width(input int strb_width);
        return (strb_width > 1) ? $clog2(strb_width) : 0;
    endfunction

endpackage

// File: rtl/native_ram_mem.sv
// Single-port byte-lane RAM with registered read port; one 8-bit array per lane
// so each lane maps cleanly onto block RAM byte-write enables.
module native_ram_mem
    import native_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_en,
    input  logic [STRB_WIDTH-1:0]     we,
    input  logic [MEM_ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH-1:0]     rdata
);

    localparam int DEPTH = 1 << MEM_ADDR_WIDTH;

    genvar gi;
    generate
        for (gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_mem_reg [DEPTH];
            logic [7:0] lane_rdata_reg;

            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    lane_mem_reg[addr] <= wdata[gi*8 +: 8];
                end
            end

            // Output register only loads on reads, so writes leave rdata untouched.
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_rdata_reg <= 8'd0;
                end else if (rd_en) begin
                    lane_rdata_reg <= lane_mem_reg[addr];
                end
            end

            assign rdata[gi*8 +: 8] = lane_rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/native_ram.sv
// Native valid/ready slave RAM with byte enables. Optional programmable wait
// states are compiled in when NATIVE_RAM_WAIT_EN is defined.
module native_ram
    import native_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int WAIT_STATES    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  native_valid,
    output logic                  native_ready,
    input  logic [ADDR_WIDTH-1:0] native_addr,
    input  logic [DATA_WIDTH-1:0] native_wdata,
    input  logic [STRB_WIDTH-1:0] native_wstrb,
    output logic [DATA_WIDTH-1:0] native_rdata
);

    localparam int OFF_WIDTH = byte_off_width(STRB_WIDTH);

    state_t                    state_reg;
    state_t                    state_next;
    logic                      accept;
    logic                      is_read;
    logic [STRB_WIDTH-1:0]     mem_we;
    logic [MEM_ADDR_WIDTH-1:0] word_addr;
    logic                      unused_addr;

    // Request fields matter only on this edge; the memory commits immediately.
    assign accept       = (state_reg == IDLE) && native_valid && !rst;
    assign is_read      = (native_wstrb == '0);
    assign mem_we       = accept ? native_wstrb : '0;
    assign word_addr    = native_addr[MEM_ADDR_WIDTH+OFF_WIDTH-1 -: MEM_ADDR_WIDTH];
    assign native_ready = (state_reg == RESP) && !rst;
    assign unused_addr  = ^native_addr;

`ifdef NATIVE_RAM_WAIT_EN
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [3:0] cnt_reg;
    logic [3:0] cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= 4'd0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end
`else
    logic [31:0] unused_wait;
    assign unused_wait = 32'(WAIT_STATES);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
`ifdef NATIVE_RAM_WAIT_EN
        cnt_next   = cnt_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (native_valid) begin
`ifdef NATIVE_RAM_WAIT_EN
                    if (WAIT_STATES > 0) begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end else begin
                        state_next = RESP;
                    end
`else
                    state_next = RESP;
`endif
                end
            end
`ifdef NATIVE_RAM_WAIT_EN
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
`endif
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    native_ram_mem #(
        .DATA_WIDTH     (DATA_WIDTH),
        .STRB_WIDTH     (STRB_WIDTH),
        .MEM_ADDR_WIDTH (MEM_ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .rd_en (accept && is_read),
        .we    (mem_we),
        .addr  (word_addr),
        .wdata (native_wdata),
        .rdata (native_rdata)
    );

endmodule

// File: tb/tb_native_ram.sv
// Self-checking bench for native_ram; expected latency follows NATIVE_RAM_WAIT_EN.
module tb_native_ram;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int SW    = 4;
    localparam int MAW   = 10;
    localparam int WS    = 3;
    localparam int DEPTH = 1 << MAW;
`ifdef NATIVE_RAM_WAIT_EN
    localparam int W_EFF = WS;
`else
    localparam int W_EFF = 0;
`endif

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic          valid = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [DW-1:0] wdata = '0;
    logic [SW-1:0] wstrb = '0;
    logic          ready;
    logic [DW-1:0] rdata;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_rdata = 32'd0;

    native_ram #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .STRB_WIDTH     (SW),
        .MEM_ADDR_WIDTH (MAW),
        .WAIT_STATES    (WS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .native_valid (valid),
        .native_ready (ready),
        .native_addr  (addr),
        .native_wdata (wdata),
        .native_wstrb (wstrb),
        .native_rdata (rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the memory is an array of words indexed modulo its depth.
    task automatic model_accept(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'((a >> 2) % DEPTH);
        if (s == 4'd0) begin
            exp_rdata = model_mem[idx];
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) model_mem[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
    endtask

    // Caller guarantees the DUT is idle. drop=1 releases valid and scrambles the
    // request fields right after the accept edge.
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input bit drop);
        int n;
        bit got;
        addr  = a;
        wdata = d;
        wstrb = s;
        valid = 1'b1;
        model_accept(a, d, s);
        n   = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            tick();
            n++;
            if (drop && n == 1) begin
                valid = 1'b0;
                addr  = ~a;
                wdata = ~d;
                wstrb = ~s;
            end
            if (ready === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL txn_timeout addr=%h: no ready within %0d cycles", a, n);
        end else begin
            total++;
            if (n != 1 + W_EFF) begin
                bad++;
                $display("FAIL latency addr=%h: got %0d cycles, expected %0d", a, n, 1 + W_EFF);
            end
            total++;
            if (rdata !== exp_rdata) begin
                bad++;
                $display("FAIL rdata addr=%h strb=%h: got %h, expected %h", a, s, rdata, exp_rdata);
            end
        end
        $display("txn %s addr=%h wdata=%h strb=%h drop=%0d lat=%0d rdata=%h",
                 (s == 4'd0) ? "RD" : "WR", a, d, s, drop, n, rdata);
        valid = 1'b0;
        tick();
        total++;
        if (ready !== 1'b0) begin
            bad++;
            $display("FAIL bubble addr=%h: ready=%b, expected 0", a, ready);
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        total += 2;
        if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b, expected 0", ready); end
        if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata: got %h, expected 0", rdata); end
        rst = 1'b0;
        tick();
        total++;
        if (ready !== 1'b0) begin bad++; $display("FAIL post_reset_ready: got %b, expected 0", ready); end
        run_txn(32'h40, 32'h5A5A_0F0F, 4'hF, 1'b0);
        // A write request held during reset must be ignored.
        rst   = 1'b1;
        valid = 1'b1;
        addr  = 32'h40;
        wdata = 32'hFFFF_FFFF;
        wstrb = 4'hF;
        for (int i = 0; i < 2; i++) begin
            tick();
            total += 2;
            if (ready !== 1'b0) begin bad++; $display("FAIL rst_valid_ready: got %b, expected 0", ready); end
            if (rdata !== 32'd0) begin bad++; $display("FAIL rst_valid_rdata: got %h, expected 0", rdata); end
        end
        rst   = 1'b0;
        valid = 1'b0;
        tick();
        total += 2;
        if (ready !== 1'b0) begin bad++; $display("FAIL after_rst_ready: got %b, expected 0", ready); end
        if (rdata !== 32'd0) begin bad++; $display("FAIL after_rst_rdata: got %h, expected 0", rdata); end
        run_txn(32'h40, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_write_read();
        run_txn(32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0);
        run_txn(32'h10, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_partial_alias();
        run_txn(32'h20, 32'h1122_3344, 4'hF, 1'b0);
        run_txn(32'h20, 32'hAA00_0000, 4'h8, 1'b0);
        run_txn(32'h1020, 32'h0, 4'h0, 1'b0);
        total++;
        if (rdata !== 32'hAA22_3344) begin
            bad++;
            $display("FAIL alias_value: got %h, expected aa223344", rdata);
        end
    endtask

    task automatic test_latency();
        run_txn(32'h10, 32'h0, 4'h0, 1'b0);
        run_txn(32'h30, 32'hCAFE_F00D, 4'h3, 1'b1);
        run_txn(32'h30, 32'h0, 4'h0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        int n;
        bit got;
        addrs[0] = 32'h0;
        addrs[1] = 32'h4;
        addrs[2] = 32'h8;
        for (int i = 0; i < 3; i++) begin
            run_txn(addrs[i], 32'h0101_0101 * (i + 3), 4'hF, 1'b0);
        end
        wstrb = 4'h0;
        valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k < 3) begin
                addr = addrs[k];
                model_accept(addrs[k], 32'h0, 4'h0);
            end else begin
                addr  = 32'h0;
                wdata = 32'h7777_7777;
                wstrb = 4'hF;
                model_accept(32'h0, 32'h7777_7777, 4'hF);
            end
            n   = 0;
            got = 1'b0;
            while (!got && n < 40) begin
                tick();
                n++;
                if (ready === 1'b1) got = 1'b1;
            end
            total += 2;
            if (!got) begin
                bad++;
                $display("FAIL b2b_timeout k=%0d: no ready within %0d cycles", k, n);
            end else if (n != ((k == 0) ? 1 + W_EFF : 2 + W_EFF)) begin
                bad++;
                $display("FAIL b2b_spacing k=%0d: got %0d cycles, expected %0d", k, n,
                         (k == 0) ? 1 + W_EFF : 2 + W_EFF);
            end
            if (rdata !== exp_rdata) begin
                bad++;
                $display("FAIL b2b_rdata k=%0d: got %h, expected %h", k, rdata, exp_rdata);
            end
            $display("txn B2B k=%0d addr=%h strb=%h gap=%0d rdata=%h", k, addr, wstrb, n, rdata);
        end
        valid = 1'b0;
        tick();
        total++;
        if (rdata !== 32'h0505_0505) begin
            bad++;
            $display("FAIL b2b_hold: got %h, expected 05050505", rdata);
        end
    endtask

    task automatic test_mid_reset();
        addr  = 32'h50;
        wdata = 32'h1357_9BDF;
        wstrb = 4'hF;
        valid = 1'b1;
        model_accept(32'h50, 32'h1357_9BDF, 4'hF);
        tick();
        valid = 1'b0;
        rst   = 1'b1;
        exp_rdata = 32'd0;
        #1;
        for (int i = 0; i < 2 + W_EFF + 3; i++) begin
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL mid_reset_ready cycle=%0d: got %b, expected 0", i, ready);
            end
            tick();
            if (i == 1) rst = 1'b0;
        end
        total++;
        if (rdata !== 32'd0) begin bad++; $display("FAIL mid_reset_rdata: got %h, expected 0", rdata); end
        $display("txn MIDRST addr=00000050 abandoned");
        run_txn(32'h50, 32'h0, 4'h0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        for (int i = 0; i < 16; i++) begin
            run_txn(32'h100 + 32'(i * 4), $urandom, 4'hF, 1'b0);
        end
        for (int i = 0; i < 40; i++) begin
            a = {$urandom_range(0, 255) * 32'h1000} + 32'h100
                + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            d = $urandom;
            s = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            run_txn(a, d, s, 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_partial_alias();
        test_latency();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
